// File: rtl/reg_wb_arbiter.sv
// Two-source writeback arbiter for the register file's single write port.
// Round-robin or fixed-priority grant with a source-1 starvation guard; output is registered.
module reg_wb_arbiter #(
   parameter int unsigned PRIORITY_MODE = 0,
   parameter int unsigned MAX_WAIT      = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s0_valid,
   input  logic [4:0]  s0_addr,
   input  logic [31:0] s0_data,
   output logic        s0_ready,
   input  logic        s1_valid,
   input  logic [4:0]  s1_addr,
   input  logic [31:0] s1_data,
   output logic        s1_ready,
   output logic [4:0]  rd_addr,
   output logic        rd_write_enable,
   output logic [31:0] rd_write_data,
   output logic [3:0]  s1_wait_cnt
);

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   logic        last_grant_q, last_grant_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic [4:0]  rd_addr_q, rd_addr_d;
   logic        rd_we_q, rd_we_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        gnt0, gnt1;

   // Grant selection; reset holds both readies low.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         if (s0_valid && s1_valid) begin
            if (PRIORITY_MODE == 0) begin
               if (last_grant_q) gnt0 = 1'b1;
               else              gnt1 = 1'b1;
            end else begin
               if (wait_cnt_q == MAX_WAIT_C) gnt1 = 1'b1;
               else                          gnt0 = 1'b1;
            end
         end else begin
            gnt0 = s0_valid;
            gnt1 = s1_valid;
         end
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      wait_cnt_d   = 4'd0;
      rd_addr_d    = rd_addr_q;
      rd_data_d    = rd_data_q;
      rd_we_d      = 1'b0;
      if (gnt0) begin
         last_grant_d = 1'b0;
         rd_addr_d    = s0_addr;
         rd_data_d    = s0_data;
         rd_we_d      = (s0_addr != 5'd0);
      end else if (gnt1) begin
         last_grant_d = 1'b1;
         rd_addr_d    = s1_addr;
         rd_data_d    = s1_data;
         rd_we_d      = (s1_addr != 5'd0);
      end
      // Starvation counter only runs in fixed-priority mode.
      if (PRIORITY_MODE != 0 && s1_valid && !gnt1) begin
         if (wait_cnt_q < MAX_WAIT_C) wait_cnt_d = wait_cnt_q + 4'd1;
         else                         wait_cnt_d = wait_cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= 1'b1;
         wait_cnt_q   <= 4'd0;
         rd_addr_q    <= 5'd0;
         rd_we_q      <= 1'b0;
         rd_data_q    <= 32'd0;
      end else begin
         last_grant_q <= last_grant_d;
         wait_cnt_q   <= wait_cnt_d;
         rd_addr_q    <= rd_addr_d;
         rd_we_q      <= rd_we_d;
         rd_data_q    <= rd_data_d;
      end
   end

   assign s0_ready        = gnt0;
   assign s1_ready        = gnt1;
   assign rd_addr         = rd_addr_q;
   assign rd_write_enable = rd_we_q;
   assign rd_write_data   = rd_data_q;
   assign s1_wait_cnt     = wait_cnt_q;

endmodule
